sfx_playback_ctrl: RTL

//  Schedules playback of NUM_SFX sound effects stored back-to-back in one shared, 1-cycle-latency sample ROM.

---
 rtl/sfx_pkg.sv | 20 ++
 rtl/sample_tick_gen.sv | 29 ++
 rtl/sfx_playback_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect playback controller.
package sfx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        PLAY  = 2'd3
    } state_t;

    // Effect indices; a higher index wins arbitration
    localparam int SFX_0 = 0;
    localparam int SFX_1 = 1;
    localparam int SFX_2 = 2;
    localparam int SFX_3 = 3;

    // 50 MHz / ~44.1 kHz
    localparam int DEFAULT_SAMPLE_DIV = 1134;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: one-cycle tick every SAMPLE_DIV clocks.
module sample_tick_gen
    import sfx_pkg::*;
#(
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic tick_o
);

    localparam int               CNT_W   = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_MAX);
    assign cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sfx_playback_ctrl.sv
// Arbitrates sound-effect triggers, paces reads of the shared 1-cycle-latency
// sample ROM at the audio rate and hands samples to the codec via valid/ready.
module sfx_playback_ctrl
    import sfx_pkg::*;
#(
    parameter int NUM_SFX    = 4,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 17,
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [NUM_SFX-1:0]         trig,
    input  logic [NUM_SFX*ADDR_W-1:0]  sfx_base,
    input  logic [NUM_SFX*ADDR_W-1:0]  sfx_len,
    output logic [ADDR_W-1:0]          rom_addr,
    output logic                       rom_enable,
    input  logic [DATA_W-1:0]          rom_data,
    output logic [DATA_W-1:0]          sample_out,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    output logic                       busy,
    output logic [$clog2(NUM_SFX)-1:0] cur_sfx,
    output logic [7:0]                 drop_cnt
);

    localparam int                 IDX_W     = $clog2(NUM_SFX);
    localparam logic [NUM_SFX-1:0] GRANT_ONE = NUM_SFX'(1);

    function automatic logic [IDX_W-1:0] prio_enc(input logic [NUM_SFX-1:0] req);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_SFX; i++) begin
            if (req[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    state_t              state_q;
    logic [NUM_SFX-1:0]  pending_q;
    logic [NUM_SFX-1:0]  pending_d;
    logic [ADDR_W-1:0]   offset_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                rom_enable_q;
    logic [DATA_W-1:0]   sample_out_q;
    logic                sample_valid_q;
    logic                busy_q;
    logic [IDX_W-1:0]    cur_sfx_q;
    logic [7:0]          drop_cnt_q;

    logic                tick;
    logic [NUM_SFX-1:0]  len_nz;
    logic [NUM_SFX-1:0]  pend_eff;
    logic [NUM_SFX-1:0]  grant_mask;
    logic [IDX_W-1:0]    grant;
    logic [ADDR_W-1:0]   grant_base;
    logic [ADDR_W-1:0]   grant_len;
    logic [ADDR_W-1:0]   offset_inc;
    logic                last_sample;
    logic                preempt;
    logic                launch;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk_i  (Clk),
        .rst_n_i(Reset_n),
        .tick_o (tick)
    );

    // Triggers are ORed in combinationally so a trigger coinciding with a tick
    // takes part in that tick's grant decision.
    always_comb begin
        len_nz = '0;
        for (int i = 0; i < NUM_SFX; i++) begin
            len_nz[i] = |sfx_len[i*ADDR_W +: ADDR_W];
        end
        pend_eff    = pending_q | (trig & len_nz);
        grant       = prio_enc(pend_eff);
        grant_base  = sfx_base[grant*ADDR_W +: ADDR_W];
        grant_len   = sfx_len[grant*ADDR_W +: ADDR_W];
        offset_inc  = offset_q + ADDR_W'(1);
        last_sample = (offset_inc == len_q);
        // Any pending index at or above the current one: preemption or restart
        preempt     = ((pend_eff >> cur_sfx_q) != '0);
        case (state_q)
            IDLE:    launch = tick && (pend_eff != '0);
            PLAY:    launch = tick && (preempt || (last_sample && (pend_eff != '0)));
            default: launch = 1'b0;
        endcase
        grant_mask = launch ? (GRANT_ONE << grant) : '0;
        pending_d  = pend_eff & ~grant_mask;
    end

    // state | meaning
    // IDLE  | nothing playing; wait for a pending effect and a tick
    // FETCH | ROM read issued for base+offset
    // WAIT  | ROM data arriving; latched into sample_out at the end of this cycle
    // PLAY  | sample held for the codec; next tick advances, restarts or finishes
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            offset_q       <= '0;
            base_q         <= '0;
            len_q          <= '0;
            rom_addr_q     <= '0;
            rom_enable_q   <= 1'b0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            cur_sfx_q      <= '0;
            drop_cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;

            if (launch) begin
                state_q      <= FETCH;
                cur_sfx_q    <= grant;
                base_q       <= grant_base;
                len_q        <= grant_len;
                offset_q     <= '0;
                rom_addr_q   <= grant_base;
                rom_enable_q <= 1'b1;
                busy_q       <= 1'b1;
            end else begin
                case (state_q)
                    FETCH: state_q <= WAIT;
                    WAIT: begin
                        state_q      <= PLAY;
                        rom_enable_q <= 1'b0;
                    end
                    PLAY: begin
                        if (tick) begin
                            if (last_sample) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q      <= FETCH;
                                offset_q     <= offset_inc;
                                rom_addr_q   <= base_q + offset_inc;
                                rom_enable_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end

            // An unaccepted sample overwritten by a new one counts as a drop
            if (state_q == WAIT) begin
                sample_out_q   <= rom_data;
                sample_valid_q <= 1'b1;
                if (sample_valid_q && !sample_ready && (drop_cnt_q != 8'hFF)) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end else if (sample_valid_q && sample_ready) begin
                sample_valid_q <= 1'b0;
            end
        end
    end

    assign rom_addr     = rom_addr_q;
    assign rom_enable   = rom_enable_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign cur_sfx      = cur_sfx_q;
    assign drop_cnt     = drop_cnt_q;

endmodule
